virtio_used_ring_writer: RTL
============================

// Module: virtio_used_ring_writer
// PURPOSE
//  Device-side writer for the virtio used ring: the producer counterpart of the available-ring
//  consumer. Accepts completed-descriptor elements {id,len} per queue on an AXI4-Stream and emits
//  AXI4-Stream memory-write requests. Each element goes to the used ring; the used index is published
//  per batch. Sits between the descriptor-completion logic and the host-memory write DMA.
// PARAMETERS
//  QUEUES          4   number of virtqueues; tid width = $clog2(QUEUES)
//  MAX_BATCH       8   elements written before a forced used-index publish (1..65535)
// PORTS
//  aclk              in   1          clock; all logic on rising edge
//  areset            in   1          synchronous, active-high reset
//  rx_tvalid/tready  in/out 1        element handshake
//  rx_tdata          in   64         [31:0]=descriptor id, [63:32]=written length
//  rx_tid            in   2          queue number
//  rx_tlast          in   1          last element of a completion burst -> publish used index
//  tx_tvalid/tready  out/in 1        write-request handshake
//  tx_tdata          out  64         beat0 = byte address, beat1 = write data
//  tx_tkeep          out  8          beat0 8'hFF; element data 8'hFF; index data 8'h03
//  tx_tid            out  2          queue number of the request
//  tx_tlast          out  1          set on beat1 of every request
//  used_ring_base    in   QUEUES*64  per-queue used-ring base address (8-byte aligned)
//  queue_size_log2   in   QUEUES*4   per-queue log2 ring size, 0..15
//  queue_reset       in   QUEUES     per-queue pulse: clear used index and pending count
//  notify_valid      out  1          one-cycle pulse after a used-index write completes
//  notify_queue      out  2          queue whose index was published
// BEHAVIOUR
//  - Reset: all outputs 0 (rx_tready=0, tx_tvalid=0, tx_tlast=0, tx_tdata=0, tx_tkeep=0,
//    tx_tid=0, notify_valid=0). All used_idx[q]=0, pending=0. State IDLE. Aborts any in-flight request.
//  - FSM: IDLE -> ELEM_ADDR -> ELEM_DATA -> (IDLE | IDX_ADDR -> IDX_DATA -> IDLE).
//  - IDLE: rx_tready=1 unless a flush is needed. On accept, latch id/len/tid/tlast.
//    Element accepted at cycle N gives tx_tvalid with the address beat at N+1.
//  - ELEM_ADDR address = base[q] + 4 + 8*(used_idx[q] & ((1<<size_log2[q])-1)).
//    This is a 64-bit add; carry out is discarded.
//  - ELEM_DATA data = {len,id}. On its handshake: used_idx[q] += 1 (16-bit, wraps 16'hFFFF->0);
//    pending += 1. Go to IDX_ADDR if the latched tlast is set or pending==MAX_BATCH, else to IDLE.
//  - IDX_ADDR address = base[q]+2. IDX_DATA data = {48'b0, used_idx[q]}, tkeep=8'h03.
//    On handshake: pending=0, notify_valid=1 for one cycle, notify_queue=q.
//  - Element writes always precede the index write covering them (virtio ordering).
//  - Queue switch: if rx_tvalid has rx_tid != pending queue and pending>0, hold rx_tready=0.
//    Flush (IDX_ADDR/IDX_DATA) the pending queue first, then accept the new element.
//  - AXI rules: once tx_tvalid=1, tdata/tkeep/tid/tlast are held stable until tx_tready.
//    Back-to-back beats with no bubble when tx_tready stays high.
//  - queue_reset[q]: used_idx[q]=0. Pending is cleared if q is the pending queue.
//    An in-flight request completes with its latched values.
//    Reset wins over the same-cycle increment (result 0).
//  - areset mid-request: tx_tvalid drops the next cycle; no completion notify is issued.
//  - Throughput: 1 element per 3 cycles best case (accept, addr, data).
// STRUCTURE
//  - Package virtio_used_ring_pkg holds:
//    used_elem_t packed struct {len[31:0], id[31:0]};
//    state_t enum; constants USED_IDX_OFFSET=2, USED_RING_OFFSET=4, USED_ELEM_BYTES=8.
//  - Sub-module virtio_used_ring_index_table holds the per-queue 16-bit counters.
//    It provides increment, queue_reset and read port; the reset-wins rule lives there.
//  - The top holds the FSM, element/address registers and pending counter.
// TESTING
//  1. q0 base 0x1000, size_log2 3: send id=5,len=64,tlast=1.
//     -> tx: (0x1004,{64,5}) then (0x1002, 0x0001, tkeep 03); notify q0.
//  2. q1 size_log2 2, 5 elements, tlast on the 5th.
//     -> 5th element address wraps to base+4. Index data reads 5. Exactly one notify.
//  3. MAX_BATCH=8: 10 elements on q0, tlast only on the 10th.
//     -> index writes after the 8th (idx 8) and after the 10th (idx 10).
//  4. q0 element without tlast, then a q2 element.
//     -> rx_tready low until the q0 index write (idx 1) finishes, then q2 is accepted.
//  5. Preload used_idx[q0]=16'hFFFF, one element with tlast.
//     -> index data 0. Random tx_tready stalls: beats stable, no loss or duplication.
//  6. queue_reset[0] during ELEM_DATA stall -> request completes; next index write carries 1 for the next element.
//     areset mid-beat -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/virtio_used_ring_pkg.sv
// Shared types and layout constants for the virtio used-ring writer.
package virtio_used_ring_pkg;

   typedef struct packed {
      logic [31:0] len;
      logic [31:0] id;
   } used_elem_t;

   typedef enum logic [2:0] {
      IDLE,
      ELEM_ADDR,
      ELEM_DATA,
      IDX_ADDR,
      IDX_DATA
   } state_t;

   // Byte offsets inside a used ring: flags(2) idx(2) ring[](8 each)
   localparam logic [63:0] USED_IDX_OFFSET  = 64'd2;
   localparam logic [63:0] USED_RING_OFFSET = 64'd4;
   localparam logic [63:0] USED_ELEM_BYTES  = 64'd8;

endpackage

// File: rtl/virtio_used_ring_index_table.sv
// Per-queue 16-bit used-index counters with a single read port.
module virtio_used_ring_index_table #(
   parameter  int unsigned QUEUES = 4,
   localparam int unsigned QW     = $clog2(QUEUES)
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              inc,
   input  logic [QW-1:0]     inc_q,
   input  logic [QUEUES-1:0] queue_reset,
   input  logic [QW-1:0]     rd_q,
   output logic [15:0]       rd_idx
);

   logic [15:0] used_idx [QUEUES];

   // A queue reset overrides an increment landing in the same cycle.
   always_ff @(posedge aclk) begin
      for (int unsigned q = 0; q < QUEUES; q++) begin
         if (areset || queue_reset[q]) begin
            used_idx[q] <= '0;
         end else if (inc && inc_q == QW'(q)) begin
            used_idx[q] <= used_idx[q] + 16'd1;
         end
      end
   end

   assign rd_idx = used_idx[rd_q];

endmodule

// File: rtl/virtio_used_ring_writer.sv
// Device-side virtio used-ring writer: turns {id,len} completions into
// element writes plus batched used-index writes on an AXI4-Stream request port.
module virtio_used_ring_writer
   import virtio_used_ring_pkg::*;
#(
   parameter  int unsigned QUEUES    = 4,
   parameter  int unsigned MAX_BATCH = 8,
   localparam int unsigned QW        = $clog2(QUEUES)
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 rx_tvalid,
   output logic                 rx_tready,
   input  logic [63:0]          rx_tdata,
   input  logic [QW-1:0]        rx_tid,
   input  logic                 rx_tlast,
   output logic                 tx_tvalid,
   input  logic                 tx_tready,
   output logic [63:0]          tx_tdata,
   output logic [7:0]           tx_tkeep,
   output logic [QW-1:0]        tx_tid,
   output logic                 tx_tlast,
   input  logic [QUEUES*64-1:0] used_ring_base,
   input  logic [QUEUES*4-1:0]  queue_size_log2,
   input  logic [QUEUES-1:0]    queue_reset,
   output logic                 notify_valid,
   output logic [QW-1:0]        notify_queue
);

   state_t        state, state_n;
   used_elem_t    elem;
   logic [QW-1:0] q_r;
   logic          last_r;
   logic [15:0]   pending;
   logic [63:0]   base [QUEUES];
   logic [3:0]    lg   [QUEUES];
   logic [QW-1:0] rd_q;
   logic [15:0]   rd_idx;
   logic [15:0]   slot;
   logic [63:0]   elem_addr;
   logic          inc, accept, flush_done, ready_c;
   logic          tx_valid_n, tx_last_n;
   logic [63:0]   tx_data_n;
   logic [7:0]    tx_keep_n;
   logic [QW-1:0] tx_tid_n;

   always_comb begin
      for (int unsigned q = 0; q < QUEUES; q++) begin
         base[q] = used_ring_base[q*64 +: 64];
         lg[q]   = queue_size_log2[q*4 +: 4];
      end
   end

   virtio_used_ring_index_table #(.QUEUES(QUEUES)) u_index_table (
      .aclk        (aclk),
      .areset      (areset),
      .inc         (inc),
      .inc_q       (q_r),
      .queue_reset (queue_reset),
      .rd_q        (rd_q),
      .rd_idx      (rd_idx)
   );

   // In IDLE the read port looks at the incoming queue to form the element address.
   assign rd_q      = (state == IDLE) ? rx_tid : q_r;
   assign slot      = rd_idx & 16'((17'd1 << lg[rx_tid]) - 17'd1);
   assign elem_addr = base[rx_tid] + USED_RING_OFFSET + 64'(slot) * USED_ELEM_BYTES;
   assign rx_tready = ready_c & ~areset;

   always_comb begin
      state_n    = state;
      ready_c    = 1'b0;
      accept     = 1'b0;
      inc        = 1'b0;
      flush_done = 1'b0;
      tx_valid_n = tx_tvalid;
      tx_data_n  = tx_tdata;
      tx_keep_n  = tx_tkeep;
      tx_tid_n   = tx_tid;
      tx_last_n  = tx_tlast;
      unique case (state)
         IDLE: begin
            if (rx_tvalid && pending != '0 && rx_tid != q_r) begin
               state_n    = IDX_ADDR;
               tx_valid_n = 1'b1;
               tx_data_n  = base[q_r] + USED_IDX_OFFSET;
               tx_keep_n  = 8'hFF;
               tx_tid_n   = q_r;
               tx_last_n  = 1'b0;
            end else begin
               ready_c = 1'b1;
               if (rx_tvalid) begin
                  accept     = 1'b1;
                  state_n    = ELEM_ADDR;
                  tx_valid_n = 1'b1;
                  tx_data_n  = elem_addr;
                  tx_keep_n  = 8'hFF;
                  tx_tid_n   = rx_tid;
                  tx_last_n  = 1'b0;
               end
            end
         end
         ELEM_ADDR: begin
            if (tx_tready) begin
               state_n   = ELEM_DATA;
               tx_data_n = elem;
               tx_last_n = 1'b1;
            end
         end
         ELEM_DATA: begin
            if (tx_tready) begin
               inc = 1'b1;
               if (last_r || ({1'b0, pending} + 17'd1) == 17'(MAX_BATCH)) begin
                  state_n   = IDX_ADDR;
                  tx_data_n = base[q_r] + USED_IDX_OFFSET;
                  tx_keep_n = 8'hFF;
                  tx_last_n = 1'b0;
               end else begin
                  state_n    = IDLE;
                  tx_valid_n = 1'b0;
                  tx_data_n  = '0;
                  tx_keep_n  = '0;
                  tx_tid_n   = '0;
                  tx_last_n  = 1'b0;
               end
            end
         end
         IDX_ADDR: begin
            // Index value is captured here, after the covering element increments.
            if (tx_tready) begin
               state_n   = IDX_DATA;
               tx_data_n = {48'd0, rd_idx};
               tx_keep_n = 8'h03;
               tx_last_n = 1'b1;
            end
         end
         IDX_DATA: begin
            if (tx_tready) begin
               flush_done = 1'b1;
               state_n    = IDLE;
               tx_valid_n = 1'b0;
               tx_data_n  = '0;
               tx_keep_n  = '0;
               tx_tid_n   = '0;
               tx_last_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= IDLE;
         tx_tvalid    <= 1'b0;
         tx_tdata     <= '0;
         tx_tkeep     <= '0;
         tx_tid       <= '0;
         tx_tlast     <= 1'b0;
         elem         <= '0;
         q_r          <= '0;
         last_r       <= 1'b0;
         notify_valid <= 1'b0;
         notify_queue <= '0;
      end else begin
         state        <= state_n;
         tx_tvalid    <= tx_valid_n;
         tx_tdata     <= tx_data_n;
         tx_tkeep     <= tx_keep_n;
         tx_tid       <= tx_tid_n;
         tx_tlast     <= tx_last_n;
         notify_valid <= flush_done;
         if (flush_done) notify_queue <= q_r;
         if (accept) begin
            elem   <= used_elem_t'(rx_tdata);
            q_r    <= rx_tid;
            last_r <= rx_tlast;
         end
      end
   end

   // Pending only ever counts elements of queue q_r.
   always_ff @(posedge aclk) begin
      if (areset || queue_reset[q_r] || flush_done) begin
         pending <= '0;
      end else if (inc) begin
         pending <= pending + 16'd1;
      end
   end

endmodule
